// File: rtl/alu_arbiter.sv
// Round-robin sharing of one single-cycle ALU between two requesters.
// The result and flags are held in a one-entry tagged response buffer.
module alu_arbiter #(
  parameter int WORD_W = 32,
  parameter int AOP_W  = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WORD_W-1:0] req0_porta,
  input  logic [WORD_W-1:0] req0_portb,
  input  logic [AOP_W-1:0]  req0_aluop,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WORD_W-1:0] req1_porta,
  input  logic [WORD_W-1:0] req1_portb,
  input  logic [AOP_W-1:0]  req1_aluop,
  output logic [WORD_W-1:0] alu_porta,
  output logic [WORD_W-1:0] alu_portb,
  output logic [AOP_W-1:0]  alu_aluop,
  input  logic [WORD_W-1:0] alu_outport,
  input  logic              alu_neg,
  input  logic              alu_over,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_outport,
  output logic              rsp_neg,
  output logic              rsp_over,
  output logic              rsp_zero
);

  logic              vld_p1;
  logic              id_p1;
  logic [WORD_W-1:0] out_p1;
  logic              neg_p1;
  logic              over_p1;
  logic              zero_p1;
  logic              last_grant;

  logic              can_accept;
  logic              gnt_vld;
  logic              gnt_id;

  // Grant is also gated by nRST so no requester sees ready while in reset.
  always_comb begin
    can_accept = !vld_p1 || rsp_ready;
    gnt_vld    = 1'b0;
    gnt_id     = 1'b0;
    if (nRST && can_accept) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_vld && !gnt_id;
  assign req1_ready = gnt_vld &&  gnt_id;

  always_comb begin
    alu_porta = '0;
    alu_portb = '0;
    alu_aluop = '0;
    if (gnt_vld) begin
      if (gnt_id) begin
        alu_porta = req1_porta;
        alu_portb = req1_portb;
        alu_aluop = req1_aluop;
      end else begin
        alu_porta = req0_porta;
        alu_portb = req0_portb;
        alu_aluop = req0_aluop;
      end
    end
  end

  // Stage p1: response buffer, written only on a grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p1     <= 1'b0;
      id_p1      <= 1'b0;
      out_p1     <= '0;
      neg_p1     <= 1'b0;
      over_p1    <= 1'b0;
      zero_p1    <= 1'b0;
      last_grant <= 1'b1;
    end else if (gnt_vld) begin
      vld_p1     <= 1'b1;
      id_p1      <= gnt_id;
      out_p1     <= alu_outport;
      neg_p1     <= alu_neg;
      over_p1    <= alu_over;
      zero_p1    <= alu_zero;
      last_grant <= gnt_id;
    end else if (rsp_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign rsp_valid   = vld_p1;
  assign rsp_id      = id_p1;
  assign rsp_outport = out_p1;
  assign rsp_neg     = neg_p1;
  assign rsp_over    = over_p1;
  assign rsp_zero    = zero_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
  localparam int WORD_W = 32;
  localparam int AOP_W  = 4;
  localparam logic [AOP_W-1:0] ALU_ADD = 4'h2;
  localparam logic [AOP_W-1:0] ALU_SUB = 4'h3;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              req0_valid, req0_ready;
  logic [WORD_W-1:0] req0_porta, req0_portb;
  logic [AOP_W-1:0]  req0_aluop;
  logic              req1_valid, req1_ready;
  logic [WORD_W-1:0] req1_porta, req1_portb;
  logic [AOP_W-1:0]  req1_aluop;
  logic [WORD_W-1:0] alu_porta, alu_portb;
  logic [AOP_W-1:0]  alu_aluop;
  logic [WORD_W-1:0] alu_outport;
  logic              alu_neg, alu_over, alu_zero;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [WORD_W-1:0] rsp_outport;
  logic              rsp_neg, rsp_over, rsp_zero;

  int tests  = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WORD_W(WORD_W), .AOP_W(AOP_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_porta(req0_porta), .req0_portb(req0_portb), .req0_aluop(req0_aluop),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_porta(req1_porta), .req1_portb(req1_portb), .req1_aluop(req1_aluop),
    .alu_porta(alu_porta), .alu_portb(alu_portb), .alu_aluop(alu_aluop),
    .alu_outport(alu_outport), .alu_neg(alu_neg), .alu_over(alu_over),
    .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_outport(rsp_outport), .rsp_neg(rsp_neg), .rsp_over(rsp_over),
    .rsp_zero(rsp_zero)
  );

  // Behavioural single-cycle ALU
  always_comb begin
    alu_outport = '0;
    alu_over    = 1'b0;
    case (alu_aluop)
      ALU_ADD: begin
        alu_outport = alu_porta + alu_portb;
        alu_over = (alu_porta[31] == alu_portb[31]) && (alu_outport[31] != alu_porta[31]);
      end
      ALU_SUB: begin
        alu_outport = alu_porta - alu_portb;
        alu_over = (alu_porta[31] != alu_portb[31]) && (alu_outport[31] != alu_porta[31]);
      end
      default: alu_outport = '0;
    endcase
    alu_neg  = alu_outport[31];
    alu_zero = (alu_outport == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    req0_valid = 1'b1; req0_porta = 32'd5; req0_portb = 32'd7; req0_aluop = ALU_ADD;
    req1_valid = 1'b0; req1_porta = '0;    req1_portb = '0;    req1_aluop = '0;
    rsp_ready  = 1'b1;
    step(); step();
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
    check("rst_rsp_outport", rsp_outport, 32'd0);
    check("rst_alu_porta",  alu_porta, 32'd0);

    nRST = 1'b1;
    #1;
    check("rel_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("rel_alu_porta",  alu_porta, 32'd5);
    check("rel_alu_aluop",  {28'd0, alu_aluop}, {28'd0, ALU_ADD});

    step();
    check("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("add_rsp_id",    {31'd0, rsp_id}, 32'd0);
    check("add_outport",   rsp_outport, 32'd12);
    check("add_zero",      {31'd0, rsp_zero}, 32'd0);
    check("add_neg",       {31'd0, rsp_neg}, 32'd0);

    // Asynchronous reset between edges while a response is held
    req0_valid = 1'b0;
    nRST = 1'b0;
    #1;
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_outport",   rsp_outport, 32'd0);
    #1;
    nRST = 1'b1;

    // Contention: both valid, grants should alternate starting with 0
    req0_valid = 1'b1; req0_porta = 32'd1;  req0_portb = 32'd1; req0_aluop = ALU_ADD;
    req1_valid = 1'b1; req1_porta = 32'd10; req1_portb = 32'd1; req1_aluop = ALU_ADD;
    #1;
    check("c0_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("c0_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    check("c1_rsp_id",   {31'd0, rsp_id}, 32'd0);
    check("c1_outport",  rsp_outport, 32'd2);
    check("c1_req1_ready", {31'd0, req1_ready}, 32'd1);
    check("c1_req0_ready", {31'd0, req0_ready}, 32'd0);
    step();
    check("c2_rsp_id",   {31'd0, rsp_id}, 32'd1);
    check("c2_outport",  rsp_outport, 32'd11);
    check("c2_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    check("c3_rsp_id",   {31'd0, rsp_id}, 32'd0);
    check("c3_req1_ready", {31'd0, req1_ready}, 32'd1);
    step();
    check("c4_rsp_id",   {31'd0, rsp_id}, 32'd1);
    check("c4_outport",  rsp_outport, 32'd11);

    // Backpressure: full buffer, consumer stalled
    rsp_ready = 1'b0;
    #1;
    check("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_id",    {31'd0, rsp_id}, 32'd1);
      check("bp_outport",   rsp_outport, 32'd11);
    end

    // Drain and refill in the same cycle; signed overflow on subtract
    req0_valid = 1'b0;
    req1_porta = 32'h8000_0000; req1_portb = 32'd1; req1_aluop = ALU_SUB;
    rsp_ready  = 1'b1;
    #1;
    check("ovf_req1_ready", {31'd0, req1_ready}, 32'd1);
    check("ovf_alu_porta",  alu_porta, 32'h8000_0000);
    check("ovf_alu_aluop",  {28'd0, alu_aluop}, {28'd0, ALU_SUB});
    step();
    check("ovf_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("ovf_rsp_id",    {31'd0, rsp_id}, 32'd1);
    check("ovf_outport",   rsp_outport, 32'h7FFF_FFFF);
    check("ovf_over",      {31'd0, rsp_over}, 32'd1);
    check("ovf_neg",       {31'd0, rsp_neg}, 32'd0);

    req1_porta = 32'd3; req1_portb = 32'd3;
    step();
    check("zero_outport", rsp_outport, 32'd0);
    check("zero_flag",    {31'd0, rsp_zero}, 32'd1);
    check("zero_over",    {31'd0, rsp_over}, 32'd0);

    // Idle: ALU inputs forced to zero, buffer drains, data holds
    req1_valid = 1'b0;
    #1;
    check("idle_alu_porta", alu_porta, 32'd0);
    check("idle_alu_portb", alu_portb, 32'd0);
    check("idle_req1_ready", {31'd0, req1_ready}, 32'd0);
    step();
    check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("idle_zero_hold", {31'd0, rsp_zero}, 32'd1);
    check("idle_id_hold",   {31'd0, rsp_id}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
